data_mem: RTL and testbench

//  Word-organised data memory for the single-cycle CPU datapath (load/store stage).

---
 rtl/data_mem.sv | 40 ++++
 tb/tb_data_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Word-organised data memory for the single-cycle CPU load/store stage.
// Writes happen on the clock edge. Reads are combinational. Reset clears the whole array.
module data_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS,
    input  logic              DM_W,
    input  logic              DM_R,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  word_idx;
    logic              unused_addr_bits;

    // The byte offset and the bits above the array span are dropped, so addresses alias modulo DEPTH*4.
    assign word_idx         = addr[IDX_W+1:2];
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (CS && DM_W) begin
            mem[word_idx] <= wdata;
        end
    end

    // Reset also forces the read port to zero while it is held.
    assign rdata = (CS && DM_R && !reset) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: expected read values go into a scoreboard queue
// as the stimulus is driven and are popped and compared when rdata is sampled.
module tb_data_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              reset;
    logic              CS;
    logic              DM_W;
    logic              DM_R;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] want;
    int total;
    int bad;

    data_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .CS    (CS),
        .DM_W  (DM_W),
        .DM_R  (DM_R),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the write lands on the following rising edge.
    task automatic write_word(input logic [31:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0; addr = a; wdata = d;
        @(posedge clk);
        #1;
        DM_W = 1'b0;
    endtask

    // Reads are combinational, so rdata is sampled shortly after the inputs settle.
    task automatic set_read(input logic cs_v, input logic r_v, input logic [31:0] a);
        @(negedge clk);
        CS = cs_v; DM_W = 1'b0; DM_R = r_v; addr = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; CS = 1'b1; DM_W = 1'b0; DM_R = 1'b1; addr = 32'h0; wdata = '0;
        #1;
        exp_q.push_back(32'h0);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=%h", got, want); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL post_reset_word0 got=%h want=%h", got, want); end
    endtask

    task automatic test_write_read;
        write_word(32'h0, 32'h2);
        exp_q.push_back(32'h2);
        set_read(1'b1, 1'b1, 32'h0);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL write_read got=%h want=%h", got, want); end
    endtask

    task automatic test_async_reset;
        write_word(32'h10, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        set_read(1'b1, 1'b1, 32'h10);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL pre_reset_read got=%h want=%h", got, want); end
        // Assert reset between edges and try to write while it is held.
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL during_reset_read got=%h want=%h", got, want); end
        DM_W = 1'b1; wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; DM_W = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL reset_cleared_0x10 got=%h want=%h", got, want); end
        exp_q.push_back(32'h0);
        set_read(1'b1, 1'b1, 32'h0);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL reset_cleared_0x0 got=%h want=%h", got, want); end
    endtask

    task automatic test_chip_select;
        @(negedge clk);
        CS = 1'b0; DM_W = 1'b1; DM_R = 1'b0; addr = 32'h4; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        DM_W = 1'b0;
        exp_q.push_back(32'h0);
        set_read(1'b1, 1'b1, 32'h4);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL cs0_write_blocked got=%h want=%h", got, want); end
        write_word(32'h4, 32'hA5A5A5A5);
        exp_q.push_back(32'h0);
        set_read(1'b0, 1'b1, 32'h4);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL cs0_read_zero got=%h want=%h", got, want); end
    endtask

    task automatic test_alias;
        write_word(32'h8, 32'h12345678);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h12345678);
        set_read(1'b1, 1'b1, 32'hB);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL low_bits_ignored got=%h want=%h", got, want); end
        set_read(1'b1, 1'b1, 32'h8 + DEPTH * 4);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL addr_wrap got=%h want=%h", got, want); end
        set_read(1'b1, 1'b1, 32'h80000008);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL high_bit_alias got=%h want=%h", got, want); end
    endtask

    task automatic test_simultaneous;
        write_word(32'h20, 32'h5);
        @(negedge clk);
        CS = 1'b1; DM_R = 1'b1; DM_W = 1'b1; addr = 32'h20; wdata = 32'h9;
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h9);
        #1;
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL rw_before_edge got=%h want=%h", got, want); end
        @(posedge clk);
        #1;
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL rw_after_edge got=%h want=%h", got, want); end
        DM_W = 1'b0;
    endtask

    task automatic test_read_disable;
        exp_q.push_back(32'h0);
        set_read(1'b1, 1'b0, 32'h8);
        got = rdata; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("[TB] FAIL dm_r0_zero got=%h want=%h", got, want); end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] vals [8];
        // DM_W stays high across consecutive edges so each word is written in its own cycle.
        @(negedge clk);
        CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
            addr = 32'h100 + 32'(i * 4);
            wdata = vals[i];
            exp_q.push_back(vals[i]);
            @(negedge clk);
        end
        DM_W = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_read(1'b1, 1'b1, 32'h100 + 32'(i * 4));
            got = rdata; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL b2b_word%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_write_read();
        test_async_reset();
        test_chip_select();
        test_alias();
        test_simultaneous();
        test_read_disable();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
